// File: rtl/l1_cache_control.sv
// Direct-mapped, write-back / write-allocate L1 cache controller driving one external way
// (valid/dirty/tag/data arrays) between the LC-3b memory port and physical memory.
module l1_cache_control #(
  parameter int TAG_W  = 9,
  parameter int IDX_W  = 3,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_address,
  input  logic [15:0]       mem_wdata,
  input  logic [1:0]        mem_byte_enable,
  output logic              mem_resp,
  output logic [15:0]       mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [15:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [IDX_W-1:0]  way_index,
  output logic [TAG_W-1:0]  way_tag_in,
  output logic [3:0]        way_write,
  output logic              way_dirty_in,
  output logic [LINE_W-1:0] way_data_in,
  input  logic              way_valid_out,
  input  logic              way_dirty_out,
  input  logic [TAG_W-1:0]  way_tag_out,
  input  logic [LINE_W-1:0] way_data_out,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int OFF_W = 16 - TAG_W - IDX_W;

  typedef enum logic [1:0] {
    S_CHECK,
    S_WRITEBACK,
    S_FILL
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       hit_count_q, hit_count_d;
  logic [15:0]       miss_count_q, miss_count_d;
  logic              filled_q, filled_d;

  logic              req;
  logic              hit;
  logic [OFF_W-2:0]  word_sel;
  logic [15:0]       old_word;
  logic [15:0]       new_word;
  logic [LINE_W-1:0] merged_line;

  assign req        = mem_read | mem_write;
  assign hit        = way_valid_out && (way_tag_out == mem_address[15 -: TAG_W]);
  assign word_sel   = mem_address[OFF_W-1:1];
  assign way_index  = mem_address[OFF_W +: IDX_W];
  assign way_tag_in = mem_address[15 -: TAG_W];
  assign old_word   = way_data_out[{word_sel, 4'b0000} +: 16];
  assign mem_rdata  = old_word;
  assign new_word   = {mem_byte_enable[1] ? mem_wdata[15:8] : old_word[15:8],
                       mem_byte_enable[0] ? mem_wdata[7:0]  : old_word[7:0]};

  always_comb begin
    merged_line = way_data_out;
    merged_line[{word_sel, 4'b0000} +: 16] = new_word;
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    filled_d     = filled_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = way_data_out;
    way_write    = 4'b0000;
    way_dirty_in = 1'b0;
    way_data_in  = merged_line;

    unique case (state_q)
      S_CHECK: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            filled_d = 1'b0;
            // The response that completes a miss was already counted as a miss.
            if (!filled_q && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
            if (mem_write) begin
              way_write    = 4'b1001;
              way_dirty_in = 1'b1;
            end
          end else begin
            state_d = (way_valid_out && way_dirty_out) ? S_WRITEBACK : S_FILL;
            if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag_out, way_index, {OFF_W{1'b0}}};
        if (pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:OFF_W], {OFF_W{1'b0}}};
        if (pmem_resp) begin
          // Fill writes valid/tag/data; the dirty enable stays off.
          way_write    = 4'b0111;
          way_data_in  = pmem_rdata;
          way_dirty_in = 1'b0;
          filled_d     = 1'b1;
          state_d      = S_CHECK;
        end
      end
      default: state_d = S_CHECK;
    endcase

    if (reset) begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      way_write  = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= S_CHECK;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      filled_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      filled_q     <= filled_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
